id_ex_hazard_stage: RTL and testbench

ID/EX pipeline boundary of the 5-stage RV32I core. Registers decoded ID-stage operands and control into EX, detects load-use hazards and inserts one bubble, squashes wrong-path instructions on branch flush, and freezes on a global hold. Its ex_rs1/ex_rs2/ex_rd/ex_reg_write outputs feed the forwarding unit directly; ex_mem_read feeds back into its own hazard check.

---
 rtl/core_pkg.sv | 20 ++
 rtl/id_ex_hazard_stage_if.sv | 45 ++++
 rtl/id_ex_hazard_stage_load_use_detector.sv | 23 ++
 rtl/id_ex_hazard_stage.sv | 95 +++++++++
 tb/tb_id_ex_hazard_stage.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core pipeline.
package core_pkg;

  localparam int XLEN = 32;

  // Decoded control bundle carried alongside each instruction into EX.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  // All-zero control word: a bubble never writes registers or touches memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ID-side operand bundle and its registered EX-side copy.
// The master is the decode stage producing id_*, the slave is the ID/EX register.
interface id_ex_hazard_stage_if
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN
);

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [XLEN-1:0] id_rdata1;
  logic [XLEN-1:0] id_rdata2;
  logic [XLEN-1:0] id_imm;
  ctrl_t           id_ctrl;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_rdata1;
  logic [XLEN-1:0] ex_rdata2;
  logic [XLEN-1:0] ex_imm;
  ctrl_t           ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rdata1, id_rdata2, id_imm, id_ctrl,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2,
           ex_imm, ex_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rdata1, id_rdata2, id_imm, id_ctrl,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2,
           ex_imm, ex_ctrl
  );

endinterface

// File: rtl/id_ex_hazard_stage_load_use_detector.sv
// Load-use hazard equation: a valid load in EX whose destination is a
// source actually read by the valid instruction in ID. x0 never hazards.
module load_use_detector (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                     (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch squash and global hold.
// ex_* feed the forwarding unit; ex_ctrl.mem_read loops back into the hazard check.
module id_ex_hazard_stage
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_ex_hazard_stage_if.slave  bus,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 pc_write_en,
  output logic                 if_id_write_en,
  output logic [CNT_W-1:0]     bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load_use;
  logic front_stall;
  logic insert_bubble;

  load_use_detector u_load_use_detector (
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (bus.ex_ctrl.mem_read),
    .ex_rd       (bus.ex_rd),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .load_use    (load_use)
  );

  // A flush already replaces the ID instruction, so only an unflushed load-use stalls the front end.
  assign front_stall    = load_use && !flush;
  assign pc_write_en    = !hold && !front_stall;
  assign if_id_write_en = !hold && !front_stall;
  assign insert_bubble  = flush || load_use;

  // ID/EX register: hold freezes, flush or load-use inserts a bubble, otherwise capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_pc     <= '0;
      bus.ex_rs1    <= '0;
      bus.ex_rs2    <= '0;
      bus.ex_rd     <= '0;
      bus.ex_rdata1 <= '0;
      bus.ex_rdata2 <= '0;
      bus.ex_imm    <= '0;
      bus.ex_ctrl   <= CTRL_BUBBLE;
    end else if (!hold) begin
      if (insert_bubble) begin
        bus.ex_valid  <= 1'b0;
        bus.ex_pc     <= '0;
        bus.ex_rs1    <= '0;
        bus.ex_rs2    <= '0;
        bus.ex_rd     <= '0;
        bus.ex_rdata1 <= '0;
        bus.ex_rdata2 <= '0;
        bus.ex_imm    <= '0;
        bus.ex_ctrl   <= CTRL_BUBBLE;
      end else begin
        bus.ex_valid  <= bus.id_valid;
        bus.ex_pc     <= bus.id_pc;
        bus.ex_rs1    <= bus.id_rs1;
        bus.ex_rs2    <= bus.id_rs2;
        bus.ex_rd     <= bus.id_rd;
        bus.ex_rdata1 <= bus.id_rdata1;
        bus.ex_rdata2 <= bus.id_rdata2;
        bus.ex_imm    <= bus.id_imm;
        bus.ex_ctrl   <= bus.id_ctrl;
      end
    end
  end

  // Count bubbles caused by load-use only, saturating at the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (!hold && front_stall && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  // A load-use edge must always leave a bubble in EX on the following cycle.
  a_bubble_after_stall : assert property (
    @(posedge clk) disable iff (!rst_n)
    (load_use && !hold && !flush) |=> !bus.ex_valid
  );

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: vector table, directed
// multi-cycle sequences and random traffic against a reference model.
module tb_id_ex_hazard_stage;
  import core_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam ctrl_t LD_CTRL  = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1,
                                 mem_write: 1'b0, branch: 1'b0, alu_src: 1'b1, alu_op: 4'h0};
  localparam ctrl_t ALU_CTRL = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0,
                                 mem_write: 1'b0, branch: 1'b0, alu_src: 1'b0, alu_op: 4'h2};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             hold = 1'b0;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic [CNT_W-1:0] bubble_count;

  int errors = 0;
  int checks = 0;

  id_ex_hazard_stage_if #(.XLEN(XLEN)) bus ();

  id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .hold           (hold),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .bubble_count   (bubble_count)
  );

  always #5 clk = ~clk;

  // Reference model: what EX should hold and how many load-use bubbles occurred.
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    ctrl_t       ctrl;
  } ex_t;

  ex_t m;
  int  m_cnt;

  typedef struct {
    bit       ld_is_load;
    bit [4:0] ld_rd;
    bit       dep_valid;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit       fl;
    bit       hd;
    bit       exp_pc_we;
    bit       exp_ex_valid;
    int       exp_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic ex_t bubble_ex();
    ex_t b;
    b.valid = 1'b0; b.pc = '0; b.rs1 = '0; b.rs2 = '0; b.rd = '0;
    b.d1 = '0; b.d2 = '0; b.imm = '0; b.ctrl = '0;
    return b;
  endfunction

  function automatic ex_t capture_id();
    ex_t c;
    c.valid = bus.id_valid; c.pc = bus.id_pc; c.rs1 = bus.id_rs1; c.rs2 = bus.id_rs2;
    c.rd = bus.id_rd; c.d1 = bus.id_rdata1; c.d2 = bus.id_rdata2; c.imm = bus.id_imm;
    c.ctrl = bus.id_ctrl;
    return c;
  endfunction

  function automatic bit model_hazard();
    bit src_hit;
    src_hit = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
    return m.valid && m.ctrl.mem_read && (m.rd != 5'd0) && bus.id_valid && src_hit;
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Compare every DUT output against the model for the current inputs.
  task automatic checkOutput(string tag);
    bit exp_en;
    exp_en = !hold && !(model_hazard() && !flush);
    check({tag, ".ex_valid"},  64'(bus.ex_valid),  64'(m.valid));
    check({tag, ".ex_pc"},     64'(bus.ex_pc),     64'(m.pc));
    check({tag, ".ex_rs1"},    64'(bus.ex_rs1),    64'(m.rs1));
    check({tag, ".ex_rs2"},    64'(bus.ex_rs2),    64'(m.rs2));
    check({tag, ".ex_rd"},     64'(bus.ex_rd),     64'(m.rd));
    check({tag, ".ex_rdata1"}, 64'(bus.ex_rdata1), 64'(m.d1));
    check({tag, ".ex_rdata2"}, 64'(bus.ex_rdata2), 64'(m.d2));
    check({tag, ".ex_imm"},    64'(bus.ex_imm),    64'(m.imm));
    check({tag, ".ex_ctrl"},   64'(bus.ex_ctrl),   64'(m.ctrl));
    check({tag, ".bubble_count"},   64'(bubble_count),   64'(m_cnt));
    check({tag, ".pc_write_en"},    64'(pc_write_en),    64'(exp_en));
    check({tag, ".if_id_write_en"}, 64'(if_id_write_en), 64'(exp_en));
  endtask

  task automatic applyStimulus(bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               bit u1, bit u2, ctrl_t c, bit fl, bit hd);
    bus.id_valid    = v;
    bus.id_pc       = $urandom;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.id_rdata1   = $urandom;
    bus.id_rdata2   = $urandom;
    bus.id_imm      = $urandom;
    bus.id_ctrl     = c;
    flush           = fl;
    hold            = hd;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs present at the edge.
  task automatic step();
    ex_t nxt;
    bit  hz;
    hz  = model_hazard();
    nxt = m;
    if (!hold) begin
      if (flush || hz) nxt = bubble_ex();
      else             nxt = capture_id();
      if (!flush && hz && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    m     = bubble_ex();
    m_cnt = 0;
    checkOutput("reset");
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    m     = bubble_ex();
    m_cnt = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, '0, 0, 0);
    @(posedge clk);
    #1;

    // ld_is_load, ld_rd, dep_valid, rs1, rs2, u1, u2, flush, hold, pc_we, ex_valid, cnt
    vecs[0] = '{1, 5, 1, 5, 1, 1, 1, 0, 0, 0, 0, 1};
    vecs[1] = '{1, 0, 1, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    vecs[2] = '{1, 5, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0};
    vecs[3] = '{1, 5, 1, 2, 5, 1, 1, 0, 0, 0, 0, 1};
    vecs[4] = '{1, 5, 1, 3, 5, 1, 0, 0, 0, 1, 1, 0};
    vecs[5] = '{1, 5, 1, 5, 1, 1, 1, 1, 0, 1, 0, 0};
    vecs[6] = '{1, 5, 1, 5, 1, 1, 1, 0, 1, 0, 1, 0};
    vecs[7] = '{0, 5, 1, 5, 1, 1, 1, 0, 0, 1, 1, 0};
    vecs[8] = '{1, 5, 0, 5, 1, 1, 1, 0, 0, 1, 0, 0};
    vecs[9] = '{1, 5, 1, 7, 8, 1, 1, 1, 0, 1, 0, 0};

    for (int i = 0; i < 10; i++) begin
      doReset();
      applyStimulus(1, 0, 0, vecs[i].ld_rd, 0, 0, vecs[i].ld_is_load ? LD_CTRL : ALU_CTRL, 0, 0);
      step();
      checkOutput("vec_ld");
      applyStimulus(vecs[i].dep_valid, vecs[i].rs1, vecs[i].rs2, 6, vecs[i].u1, vecs[i].u2,
                    ALU_CTRL, vecs[i].fl, vecs[i].hd);
      check($sformatf("vec%0d.pc_we", i), 64'(pc_write_en), 64'(vecs[i].exp_pc_we));
      checkOutput("vec_dep");
      step();
      check($sformatf("vec%0d.ex_valid", i), 64'(bus.ex_valid), 64'(vecs[i].exp_ex_valid));
      check($sformatf("vec%0d.count", i), 64'(bubble_count), 64'(vecs[i].exp_cnt));
      checkOutput("vec_after");
    end

    $display("[TB] load-use sequence");
    doReset();
    applyStimulus(1, 2, 0, 5, 1, 0, LD_CTRL, 0, 0);
    step();
    applyStimulus(1, 5, 1, 6, 1, 1, ALU_CTRL, 0, 0);
    check("lu.N.pc_we", 64'(pc_write_en), 64'(0));
    checkOutput("lu.N");
    step();
    check("lu.N1.ex_valid", 64'(bus.ex_valid), 64'(0));
    check("lu.N1.pc_we", 64'(pc_write_en), 64'(1));
    checkOutput("lu.N1");
    step();
    check("lu.N2.ex_rs1", 64'(bus.ex_rs1), 64'(5));
    check("lu.N2.count", 64'(bubble_count), 64'(1));
    applyStimulus(1, 5, 2, 7, 1, 1, ALU_CTRL, 0, 0);
    check("lu.b2b.pc_we", 64'(pc_write_en), 64'(1));
    step();
    check("lu.b2b.count", 64'(bubble_count), 64'(1));
    checkOutput("lu.b2b");

    $display("[TB] reset during stall");
    applyStimulus(1, 0, 0, 5, 0, 0, LD_CTRL, 0, 0);
    step();
    applyStimulus(1, 5, 0, 6, 1, 0, ALU_CTRL, 0, 0);
    check("rst.pre.pc_we", 64'(pc_write_en), 64'(0));
    rst_n = 1'b0;
    #1;
    check("rst.ex_valid", 64'(bus.ex_valid), 64'(0));
    check("rst.count", 64'(bubble_count), 64'(0));
    m     = bubble_ex();
    m_cnt = 0;
    checkOutput("rst.async");
    #1;
    rst_n = 1'b1;
    step();
    checkOutput("rst.release");

    $display("[TB] hold with flush");
    doReset();
    applyStimulus(1, 0, 0, 9, 0, 0, LD_CTRL, 0, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 9, 9, 4, 1, 1, ALU_CTRL, 1, 1);
      check("hold.pc_we", 64'(pc_write_en), 64'(0));
      check("hold.if_id_we", 64'(if_id_write_en), 64'(0));
      step();
      check("hold.ex_rd", 64'(bus.ex_rd), 64'(9));
      checkOutput("hold");
    end
    applyStimulus(1, 9, 9, 4, 1, 1, ALU_CTRL, 1, 0);
    check("hold.release.pc_we", 64'(pc_write_en), 64'(1));
    step();
    check("hold.release.ex_valid", 64'(bus.ex_valid), 64'(0));
    check("hold.release.count", 64'(bubble_count), 64'(0));
    checkOutput("hold.release");

    $display("[TB] saturation");
    doReset();
    for (int e = 0; e < 20; e++) begin
      applyStimulus(1, 0, 0, 5, 0, 0, LD_CTRL, 0, 0);
      step();
      applyStimulus(1, 5, 0, 6, 1, 0, ALU_CTRL, 0, 0);
      step();
      checkOutput("sat");
    end
    check("sat.count", 64'(bubble_count), 64'(CNT_MAX));

    $display("[TB] random traffic");
    doReset();
    for (int r = 0; r < 400; r++) begin
      logic [31:0] rnd;
      rnd = $urandom;
      applyStimulus(rnd[0], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), rnd[1], rnd[2],
                    rnd[3] ? ctrl_t'(rnd[31:22]) : (rnd[4] ? LD_CTRL : ALU_CTRL),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      checkOutput("rand.comb");
      step();
      checkOutput("rand.seq");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
